// File: rtl/alarm_ctrl.sv
// alarm_ctrl: Moore alarm controller with three states (IDLE, SOUNDING, SILENCED).
// Edge-detects alarm_bit, counts events with saturation and blinks the LED while sounding.
// The optional auto-silence timer is compiled in with the ALARM_TIMEOUT_EN macro.
module alarm_ctrl #(
    parameter int BLINK_HALF  = 4,
    parameter int TIMEOUT_CYC = 32,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             alarm_bit,
    input  logic             ack,
    output logic             siren,
    output logic             led,
    output logic             alarm_active,
    output logic [CNT_W-1:0] event_count
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SOUNDING = 2'd1,
        SILENCED = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [7:0]       BLINK_TC = 8'(BLINK_HALF - 1);

    state_t           state_reg;
    logic             alarm_prev_reg;
    logic             led_reg;
    logic [7:0]       blink_cnt_reg;
    logic [CNT_W-1:0] event_count_reg;
    logic             event_det;
    logic             timeout_hit;

    // A new alarm is a rising edge of alarm_bit relative to the previous cycle.
    assign event_det = alarm_bit & ~alarm_prev_reg;

`ifdef ALARM_TIMEOUT_EN
    logic [15:0] timer_reg;

    assign timeout_hit = (timer_reg == 16'(TIMEOUT_CYC - 1));

    // Counts consecutive quiet SOUNDING cycles; any exit, ack or new event restarts it.
    always_ff @(posedge clk) begin
        if (reset || state_reg != SOUNDING || ack || event_det || timeout_hit) begin
            timer_reg <= 16'd0;
        end else begin
            timer_reg <= timer_reg + 16'd1;
        end
    end
`else
    logic [31:0] unused_timeout_cyc;

    // Without the timer SOUNDING is left only by ack or reset.
    assign timeout_hit        = 1'b0;
    assign unused_timeout_cyc = 32'(TIMEOUT_CYC);
`endif

    // State machine, blink phase, input history and saturating event counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            alarm_prev_reg  <= 1'b0;
            led_reg         <= 1'b0;
            blink_cnt_reg   <= 8'd0;
            event_count_reg <= '0;
        end else begin
            alarm_prev_reg <= alarm_bit;

            if (event_det && event_count_reg != CNT_MAX) begin
                event_count_reg <= event_count_reg + CNT_ONE;
            end

            case (state_reg)
                IDLE: begin
                    blink_cnt_reg <= 8'd0;
                    if (event_det) begin
                        state_reg <= SOUNDING;
                        led_reg   <= 1'b1;
                    end else begin
                        led_reg   <= 1'b0;
                    end
                end
                SOUNDING: begin
                    if (ack || timeout_hit) begin
                        // Ack wins over a simultaneous event; the event is still counted above.
                        state_reg     <= SILENCED;
                        led_reg       <= 1'b1;
                        blink_cnt_reg <= 8'd0;
                    end else if (event_det) begin
                        // Re-trigger: restart the blink phase with the LED lit.
                        led_reg       <= 1'b1;
                        blink_cnt_reg <= 8'd0;
                    end else if (blink_cnt_reg == BLINK_TC) begin
                        led_reg       <= ~led_reg;
                        blink_cnt_reg <= 8'd0;
                    end else begin
                        blink_cnt_reg <= blink_cnt_reg + 8'd1;
                    end
                end
                SILENCED: begin
                    blink_cnt_reg <= 8'd0;
                    if (!alarm_bit) begin
                        state_reg <= IDLE;
                        led_reg   <= 1'b0;
                    end else begin
                        led_reg   <= 1'b1;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    led_reg       <= 1'b0;
                    blink_cnt_reg <= 8'd0;
                end
            endcase
        end
    end

    assign siren        = (state_reg == SOUNDING);
    assign led          = led_reg;
    assign alarm_active = (state_reg != IDLE);
    assign event_count  = event_count_reg;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed self-checking bench for alarm_ctrl (default parameters).
// Follows the ALARM_TIMEOUT_EN macro to pick the expected timeout behaviour.
module tb_alarm_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       alarm_bit;
    logic       ack;
    logic       siren;
    logic       led;
    logic       alarm_active;
    logic [7:0] event_count;

    int checks = 0;
    int errors = 0;
    int exp_count = 0;

    alarm_ctrl #(.BLINK_HALF(4), .TIMEOUT_CYC(32), .CNT_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .alarm_bit    (alarm_bit),
        .ack          (ack),
        .siren        (siren),
        .led          (led),
        .alarm_active (alarm_active),
        .event_count  (event_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; alarm_bit = 1'b0; ack = 1'b0;
        tick(); tick();
        reset = 1'b0;
        exp_count = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({siren, led, alarm_active} !== 3'b000 || event_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_state: siren/led/active=%b count=%0d, need 000 count=0", {siren, led, alarm_active}, event_count);
        end
        $display("test_reset: siren=%b led=%b active=%b count=%0d", siren, led, alarm_active, event_count);
    endtask

    task automatic test_pulse();
        logic exp_led;
        do_reset();
        alarm_bit = 1'b1; tick(); alarm_bit = 1'b0; exp_count++;
        checks++;
        if (siren !== 1'b1 || alarm_active !== 1'b1 || event_count !== 8'(exp_count)) begin
            errors++;
            $display("FAIL pulse_enter: siren=%b active=%b count=%0d, need 1 1 %0d", siren, alarm_active, event_count, exp_count);
        end
        for (int k = 0; k < 8; k++) begin
            exp_led = (k < 4);
            checks++;
            if (led !== exp_led || siren !== 1'b1) begin
                errors++;
                $display("FAIL blink_k%0d: led=%b siren=%b, need led=%b siren=1", k, led, siren, exp_led);
            end
            tick();
        end
        ack = 1'b1; tick(); ack = 1'b0;
        checks++;
        if ({siren, led, alarm_active} !== 3'b011) begin
            errors++;
            $display("FAIL ack_silenced: siren/led/active=%b, need 011", {siren, led, alarm_active});
        end
        tick();
        checks++;
        if ({siren, led, alarm_active} !== 3'b000) begin
            errors++;
            $display("FAIL ack_idle: siren/led/active=%b, need 000", {siren, led, alarm_active});
        end
        $display("test_pulse: done count=%0d", event_count);
    endtask

    task automatic test_retrigger();
        do_reset();
        alarm_bit = 1'b1; tick(); alarm_bit = 1'b0; exp_count++;
        tick(); tick();
        alarm_bit = 1'b1; tick(); alarm_bit = 1'b0; exp_count++;
        checks++;
        if (siren !== 1'b1 || led !== 1'b1 || event_count !== 8'(exp_count)) begin
            errors++;
            $display("FAIL retrig_enter: siren=%b led=%b count=%0d, need 1 1 %0d", siren, led, event_count, exp_count);
        end
        for (int k = 1; k <= 4; k++) begin
            tick();
            checks++;
            if (led !== (k < 4) || siren !== 1'b1) begin
                errors++;
                $display("FAIL retrig_blink_k%0d: led=%b siren=%b, need led=%b siren=1", k, led, siren, (k < 4));
            end
        end
        ack = 1'b1; tick(); ack = 1'b0; tick();
        $display("test_retrigger: count=%0d", event_count);
    endtask

    task automatic test_same_cycle();
        do_reset();
        alarm_bit = 1'b1; tick(); alarm_bit = 1'b0; exp_count++;
        tick();
        alarm_bit = 1'b1; ack = 1'b1; tick(); exp_count++;
        checks++;
        if ({siren, led, alarm_active} !== 3'b011 || event_count !== 8'(exp_count)) begin
            errors++;
            $display("FAIL same_cycle: siren/led/active=%b count=%0d, need 011 %0d", {siren, led, alarm_active}, event_count, exp_count);
        end
        tick();
        checks++;
        if ({siren, led, alarm_active} !== 3'b011) begin
            errors++;
            $display("FAIL silenced_hold: siren/led/active=%b, need 011", {siren, led, alarm_active});
        end
        alarm_bit = 1'b0; ack = 1'b0; tick();
        checks++;
        if ({siren, led, alarm_active} !== 3'b000) begin
            errors++;
            $display("FAIL silenced_exit: siren/led/active=%b, need 000", {siren, led, alarm_active});
        end
        $display("test_same_cycle: count=%0d", event_count);
    endtask

    task automatic test_reset_mid();
        do_reset();
        alarm_bit = 1'b1; tick();
        reset = 1'b1; ack = 1'b0; tick();
        checks++;
        if ({siren, led, alarm_active} !== 3'b000 || event_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_sounding: siren/led/active=%b count=%0d, need 000 0", {siren, led, alarm_active}, event_count);
        end
        reset = 1'b0; tick();
        checks++;
        if (siren !== 1'b1 || event_count !== 8'd1) begin
            errors++;
            $display("FAIL event_after_reset: siren=%b count=%0d, need 1 1", siren, event_count);
        end
        ack = 1'b1; tick();
        reset = 1'b1; tick();
        checks++;
        if ({siren, led, alarm_active} !== 3'b000 || event_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_silenced: siren/led/active=%b count=%0d, need 000 0", {siren, led, alarm_active}, event_count);
        end
        reset = 1'b0; ack = 1'b0; alarm_bit = 1'b0; tick();
        $display("test_reset_mid: done");
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 1; i <= 300; i++) begin
            alarm_bit = 1'b1; tick(); alarm_bit = 1'b0; tick();
            if (i == 100 || i == 255 || i == 300) begin
                exp_count = (i > 255) ? 255 : i;
                checks++;
                if (event_count !== 8'(exp_count)) begin
                    errors++;
                    $display("FAIL sat_after_%0d: count=%0d, need %0d", i, event_count, exp_count);
                end
            end
        end
        $display("test_saturation: count=%0d", event_count);
    endtask

    task automatic test_timeout();
        int n = 0;
        do_reset();
        alarm_bit = 1'b1; tick(); alarm_bit = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (siren === 1'b1) n++;
            tick();
        end
`ifdef ALARM_TIMEOUT_EN
        checks++;
        if (n !== 32 || alarm_active !== 1'b0) begin
            errors++;
            $display("FAIL timeout_len: siren cycles=%0d active=%b, need 32 0", n, alarm_active);
        end
`else
        checks++;
        if (n !== 100 || siren !== 1'b1) begin
            errors++;
            $display("FAIL no_timeout: siren cycles=%0d siren=%b, need 100 1", n, siren);
        end
`endif
        $display("test_timeout: siren high for %0d cycles", n);
    endtask

    initial begin
        reset = 1'b1; alarm_bit = 1'b0; ack = 1'b0;
        test_reset();
        test_pulse();
        test_retrigger();
        test_same_cycle();
        test_reset_mid();
        test_saturation();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
